// File: rtl/spi_slv.sv
// spi_slv: SPI mode-0 slave that decodes framed register accesses
// (control word + len+1 data words) into single-cycle register-bus
// reads and writes in the clk domain. spi_sck is oversampled; all
// logic runs on clk.
module spi_slv #(
    parameter int LEN_W  = 14,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wr,
    output logic              bus_rd,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int CTRL_W  = 2 + LEN_W + ADDR_W;
    localparam int CNT_MAX = (CTRL_W > DATA_W) ? CTRL_W : DATA_W;
    localparam int BIT_W   = $clog2(CNT_MAX);

    localparam logic [BIT_W-1:0] CTRL_LAST = BIT_W'(CTRL_W - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CTRL  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Address step: +1 when incrementing, wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic inc);
        return a + {{(ADDR_W-1){1'b0}}, inc};
    endfunction

    // Synchronizer stages and previous-sck register for edge detection.
    logic sck_meta_r, sck_sync_r, sck_prev_r;
    logic cs_meta_r, cs_sync_r;
    logic mosi_meta_r, mosi_sync_r;

    logic rise_s, fall_s;

    // FSM state and datapath registers.
    state_t                state_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [LEN_W-1:0]      word_cnt_r;
    logic [LEN_W-1:0]      len_r;
    logic [ADDR_W-1:0]     addr_r;
    logic                  incr_r;
    logic [CTRL_W-2:0]     ctrl_sr_r;
    logic [DATA_W-2:0]     data_sr_r;
    logic [DATA_W-1:0]     tx_sr_r;
    logic [DATA_W-1:0]     pf_buf_r;
    logic                  rd_p1_r;     // bus_rd issued last cycle
    logic                  rd_p2_r;     // bus_rdata valid this cycle
    logic                  rd_dst_r;    // outstanding read targets the shift register (word 0)
    logic                  load_done_r; // a word was loaded into tx_sr_r last cycle
    logic                  seen_rise_r; // master has sampled the current miso bit

    logic [CTRL_W-1:0]     ctrl_word_s;
    logic                  c_rw_s;
    logic                  c_incr_s;
    logic [LEN_W-1:0]      c_len_s;
    logic [ADDR_W-1:0]     c_addr_s;
    logic [DATA_W-1:0]     wword_s;

    // Two-flop synchronizers for the SPI pins plus one register for sck edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_prev_r  <= 1'b0;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sck_meta_r  <= spi_sck;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            cs_meta_r   <= spi_cs_n;
            cs_sync_r   <= cs_meta_r;
            mosi_meta_r <= spi_mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign rise_s = sck_sync_r & ~sck_prev_r;
    assign fall_s = ~sck_sync_r & sck_prev_r;

    // Control word as it stands once the current mosi bit is appended.
    assign ctrl_word_s = {ctrl_sr_r, mosi_sync_r};
    assign c_rw_s      = ctrl_word_s[CTRL_W-1];
    assign c_incr_s    = ctrl_word_s[CTRL_W-2];
    assign c_len_s     = ctrl_word_s[ADDR_W +: LEN_W];
    assign c_addr_s    = ctrl_word_s[ADDR_W-1:0];
    assign wword_s     = {data_sr_r, mosi_sync_r};

    // Frame FSM: control decode, write assembly, read shift-out with one-word prefetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            word_cnt_r  <= '0;
            len_r       <= '0;
            addr_r      <= '0;
            incr_r      <= 1'b0;
            ctrl_sr_r   <= '0;
            data_sr_r   <= '0;
            tx_sr_r     <= '0;
            pf_buf_r    <= '0;
            rd_p1_r     <= 1'b0;
            rd_p2_r     <= 1'b0;
            rd_dst_r    <= 1'b0;
            load_done_r <= 1'b0;
            seen_rise_r <= 1'b0;
            spi_miso    <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_wr      <= 1'b0;
            bus_rd      <= 1'b0;
        end else begin
            bus_wr      <= 1'b0;
            bus_rd      <= 1'b0;
            rd_p1_r     <= 1'b0;
            rd_p2_r     <= rd_p1_r;
            load_done_r <= 1'b0;

            if (cs_sync_r) begin
                // Deselect aborts the frame; partial words and late read data are dropped.
                state_r     <= ST_IDLE;
                bit_cnt_r   <= '0;
                word_cnt_r  <= '0;
                rd_dst_r    <= 1'b0;
                seen_rise_r <= 1'b0;
                spi_miso    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r   <= ST_CTRL;
                        bit_cnt_r <= '0;
                    end

                    ST_CTRL: begin
                        if (rise_s) begin
                            ctrl_sr_r <= ctrl_word_s[CTRL_W-2:0];
                            if (bit_cnt_r == CTRL_LAST) begin
                                incr_r      <= c_incr_s;
                                len_r       <= c_len_s;
                                word_cnt_r  <= '0;
                                bit_cnt_r   <= '0;
                                seen_rise_r <= 1'b0;
                                if (c_rw_s) begin
                                    state_r <= ST_WDATA;
                                    addr_r  <= c_addr_s;
                                end else begin
                                    // Word 0 is fetched immediately; its data lands in the shift register.
                                    state_r  <= ST_RDATA;
                                    bus_rd   <= 1'b1;
                                    bus_addr <= c_addr_s;
                                    addr_r   <= next_addr(c_addr_s, c_incr_s);
                                    rd_p1_r  <= 1'b1;
                                    rd_dst_r <= 1'b1;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (rise_s) begin
                            data_sr_r <= wword_s[DATA_W-2:0];
                            if (bit_cnt_r == DATA_LAST) begin
                                bus_wr     <= 1'b1;
                                bus_addr   <= addr_r;
                                bus_wdata  <= wword_s;
                                addr_r     <= next_addr(addr_r, incr_r);
                                bit_cnt_r  <= '0;
                                word_cnt_r <= word_cnt_r + LEN_W'(1);
                                if (word_cnt_r == len_r) begin
                                    state_r <= ST_DONE;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end
                    end

                    ST_RDATA: begin
                        // Read data arrives two cycles after the strobe is registered.
                        if (rd_p2_r) begin
                            if (rd_dst_r) begin
                                tx_sr_r     <= bus_rdata;
                                spi_miso    <= bus_rdata[DATA_W-1];
                                load_done_r <= 1'b1;
                                rd_dst_r    <= 1'b0;
                            end else begin
                                pf_buf_r <= bus_rdata;
                            end
                        end

                        // Prefetch the next word right after each load, unless this is the last word.
                        if (load_done_r && (word_cnt_r != len_r)) begin
                            bus_rd   <= 1'b1;
                            bus_addr <= addr_r;
                            addr_r   <= next_addr(addr_r, incr_r);
                            rd_p1_r  <= 1'b1;
                        end

                        // Shift only on falls that follow a master sample; the fall trailing
                        // the control word therefore leaves word 0 untouched.
                        if (rise_s) begin
                            seen_rise_r <= 1'b1;
                        end else if (fall_s && seen_rise_r) begin
                            seen_rise_r <= 1'b0;
                            if (bit_cnt_r == DATA_LAST) begin
                                bit_cnt_r <= '0;
                                if (word_cnt_r == len_r) begin
                                    state_r  <= ST_DONE;
                                    spi_miso <= 1'b0;
                                end else begin
                                    tx_sr_r     <= pf_buf_r;
                                    spi_miso    <= pf_buf_r[DATA_W-1];
                                    word_cnt_r  <= word_cnt_r + LEN_W'(1);
                                    load_done_r <= 1'b1;
                                end
                            end else begin
                                tx_sr_r   <= {tx_sr_r[DATA_W-2:0], 1'b0};
                                spi_miso  <= tx_sr_r[DATA_W-2];
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end
                    end

                    ST_DONE: begin
                        spi_miso <= 1'b0;
                    end

                    default: begin
                        state_r  <= ST_IDLE;
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slv.sv
// Testbench for spi_slv: an SPI master model drives frames, a bus model
// answers reads, and monitors record bus strobes. Expected writes, read
// addresses and received words are queued when stimulus is driven and
// compared when the DUT produces them.
module tb_spi_slv;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [15:0] bus_rdata = 16'h0000;

    int n_vec = 0;
    int n_err = 0;
    int collide_cnt = 0;
    logic prev_strobe = 1'b0;
    logic miso_or;

    logic [23:0] obs_wr_q[$];
    logic [7:0]  obs_rd_q[$];
    logic [23:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [15:0] exp_rx_q[$];
    logic [15:0] rd_data_q[$];

    spi_slv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Bus model: data for a read is valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus_rd) begin
            if (rd_data_q.size() != 0) bus_rdata <= rd_data_q.pop_front();
            else                       bus_rdata <= {bus_addr, bus_addr};
        end
    end

    // Strobe monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (bus_wr) obs_wr_q.push_back({bus_addr, bus_wdata});
        if (bus_rd) obs_rd_q.push_back(bus_addr);
        if ((bus_wr && bus_rd) || ((bus_wr || bus_rd) && prev_strobe))
            collide_cnt <= collide_cnt + 1;
        prev_strobe <= bus_wr | bus_rd;
    end

    task automatic spi_bit(input logic b, output logic o);
        spi_mosi = b;
        #(HALF);
        spi_sck = 1'b1;
        o = spi_miso;
        miso_or = miso_or | spi_miso;
        #(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clk);
        #2;
        spi_cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic frame_end();
        #(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_ctrl(input logic rw, input logic incr, input logic [13:0] len,
                             input logic [7:0] addr);
        logic [23:0] w;
        logic o;
        w = {rw, incr, len, addr};
        for (int i = 23; i >= 0; i--) spi_bit(w[i], o);
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits);
        logic o;
        for (int i = 15; i > 15 - nbits; i--) spi_bit(w[i], o);
    endtask

    task automatic recv_word(output logic [15:0] w);
        logic o;
        w = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            spi_bit(1'b0, o);
            w = {w[14:0], o};
        end
    endtask

    task automatic clear_obs();
        obs_wr_q.delete();
        obs_rd_q.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_rx_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (spi_miso !== 1'b0)    begin n_err++; $display("FAIL reset_miso: got %0h want 0", spi_miso); end
        n_vec++; if (bus_wr !== 1'b0)      begin n_err++; $display("FAIL reset_wr: got %0h want 0", bus_wr); end
        n_vec++; if (bus_rd !== 1'b0)      begin n_err++; $display("FAIL reset_rd: got %0h want 0", bus_rd); end
        n_vec++; if (bus_addr !== 8'h00)   begin n_err++; $display("FAIL reset_addr: got %0h want 0", bus_addr); end
        n_vec++; if (bus_wdata !== 16'h0)  begin n_err++; $display("FAIL reset_wdata: got %0h want 0", bus_wdata); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_fixed();
        logic [23:0] e;
        clear_obs();
        miso_or = 1'b0;
        exp_wr_q.push_back({8'h3C, 16'hA55A});
        frame_start();
        send_ctrl(1'b1, 1'b0, 14'd0, 8'h3C);
        send_bits(16'hA55A, 16);
        frame_end();
        n_vec++; if (obs_wr_q.size() !== exp_wr_q.size()) begin n_err++; $display("FAIL wfix_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); end
        while (exp_wr_q.size() != 0 && obs_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            n_vec++; if (obs_wr_q[0] !== e) begin n_err++; $display("FAIL wfix_write: got %0h want %0h", obs_wr_q[0], e); end
            void'(obs_wr_q.pop_front());
        end
        n_vec++; if (miso_or !== 1'b0) begin n_err++; $display("FAIL wfix_miso: got %0h want 0", miso_or); end
        n_vec++; if (obs_rd_q.size() !== 0) begin n_err++; $display("FAIL wfix_no_rd: got %0d want 0", obs_rd_q.size()); end
    endtask

    task automatic test_write_wrap();
        logic [23:0] e;
        logic [15:0] d[3];
        clear_obs();
        d = '{16'h1111, 16'h2222, 16'h3333};
        exp_wr_q.push_back({8'hFE, d[0]});
        exp_wr_q.push_back({8'hFF, d[1]});
        exp_wr_q.push_back({8'h00, d[2]});
        frame_start();
        send_ctrl(1'b1, 1'b1, 14'd2, 8'hFE);
        for (int i = 0; i < 3; i++) send_bits(d[i], 16);
        frame_end();
        n_vec++; if (obs_wr_q.size() !== exp_wr_q.size()) begin n_err++; $display("FAIL wwrap_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); end
        while (exp_wr_q.size() != 0 && obs_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            n_vec++; if (obs_wr_q[0] !== e) begin n_err++; $display("FAIL wwrap_write: got %0h want %0h", obs_wr_q[0], e); end
            void'(obs_wr_q.pop_front());
        end
    endtask

    task automatic test_read_incr();
        logic [15:0] w, e;
        logic [7:0]  ea;
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            exp_rd_q.push_back(8'(8'h10 + i));
            exp_rx_q.push_back({8'(8'h10 + i), 8'(8'h10 + i)});
        end
        frame_start();
        send_ctrl(1'b0, 1'b1, 14'd3, 8'h10);
        #(2*HALF);
        for (int i = 0; i < 4; i++) begin
            recv_word(w);
            e = exp_rx_q.pop_front();
            n_vec++; if (w !== e) begin n_err++; $display("FAIL rinc_word%0d: got %0h want %0h", i, w, e); end
        end
        frame_end();
        n_vec++; if (obs_rd_q.size() !== exp_rd_q.size()) begin n_err++; $display("FAIL rinc_rd_count: got %0d want %0d", obs_rd_q.size(), exp_rd_q.size()); end
        while (exp_rd_q.size() != 0 && obs_rd_q.size() != 0) begin
            ea = exp_rd_q.pop_front();
            n_vec++; if (obs_rd_q[0] !== ea) begin n_err++; $display("FAIL rinc_rd_addr: got %0h want %0h", obs_rd_q[0], ea); end
            void'(obs_rd_q.pop_front());
        end
        n_vec++; if (obs_wr_q.size() !== 0) begin n_err++; $display("FAIL rinc_no_wr: got %0d want 0", obs_wr_q.size()); end
    endtask

    task automatic test_read_fixed();
        logic [15:0] w, e;
        logic [7:0]  ea;
        clear_obs();
        rd_data_q.push_back(16'hBEEF);
        rd_data_q.push_back(16'hC0DE);
        exp_rx_q.push_back(16'hBEEF);
        exp_rx_q.push_back(16'hC0DE);
        exp_rd_q.push_back(8'h20);
        exp_rd_q.push_back(8'h20);
        frame_start();
        send_ctrl(1'b0, 1'b0, 14'd1, 8'h20);
        #(2*HALF);
        for (int i = 0; i < 2; i++) begin
            recv_word(w);
            e = exp_rx_q.pop_front();
            n_vec++; if (w !== e) begin n_err++; $display("FAIL rfix_word%0d: got %0h want %0h", i, w, e); end
        end
        frame_end();
        n_vec++; if (obs_rd_q.size() !== exp_rd_q.size()) begin n_err++; $display("FAIL rfix_rd_count: got %0d want %0d", obs_rd_q.size(), exp_rd_q.size()); end
        while (exp_rd_q.size() != 0 && obs_rd_q.size() != 0) begin
            ea = exp_rd_q.pop_front();
            n_vec++; if (obs_rd_q[0] !== ea) begin n_err++; $display("FAIL rfix_rd_addr: got %0h want %0h", obs_rd_q[0], ea); end
            void'(obs_rd_q.pop_front());
        end
        rd_data_q.delete();
    endtask

    task automatic test_abort();
        logic [23:0] e;
        clear_obs();
        exp_wr_q.push_back({8'h40, 16'h1357});
        frame_start();
        send_ctrl(1'b1, 1'b1, 14'd1, 8'h40);
        send_bits(16'h1357, 16);
        send_bits(16'hFFFF, 8);
        frame_end();
        exp_wr_q.push_back({8'h55, 16'h9ABC});
        frame_start();
        send_ctrl(1'b1, 1'b0, 14'd0, 8'h55);
        send_bits(16'h9ABC, 16);
        frame_end();
        n_vec++; if (obs_wr_q.size() !== exp_wr_q.size()) begin n_err++; $display("FAIL abort_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); end
        while (exp_wr_q.size() != 0 && obs_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            n_vec++; if (obs_wr_q[0] !== e) begin n_err++; $display("FAIL abort_write: got %0h want %0h", obs_wr_q[0], e); end
            void'(obs_wr_q.pop_front());
        end
    endtask

    task automatic test_reset_midread();
        logic [23:0] e;
        logic o;
        clear_obs();
        frame_start();
        send_ctrl(1'b0, 1'b1, 14'd3, 8'h30);
        #(2*HALF);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, o);
        n_vec++; if (bus_addr !== 8'h31) begin n_err++; $display("FAIL mid_prefetch_addr: got %0h want 31", bus_addr); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (spi_miso !== 1'b0)   begin n_err++; $display("FAIL mid_rst_miso: got %0h want 0", spi_miso); end
        n_vec++; if (bus_addr !== 8'h00)  begin n_err++; $display("FAIL mid_rst_addr: got %0h want 0", bus_addr); end
        n_vec++; if (bus_rd !== 1'b0)     begin n_err++; $display("FAIL mid_rst_rd: got %0h want 0", bus_rd); end
        n_vec++; if (bus_wr !== 1'b0)     begin n_err++; $display("FAIL mid_rst_wr: got %0h want 0", bus_wr); end
        n_vec++; if (bus_wdata !== 16'h0) begin n_err++; $display("FAIL mid_rst_wdata: got %0h want 0", bus_wdata); end
        repeat (3) @(negedge clk);
        spi_cs_n = 1'b1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        clear_obs();
        exp_wr_q.push_back({8'h05, 16'h1234});
        frame_start();
        send_ctrl(1'b1, 1'b0, 14'd0, 8'h05);
        send_bits(16'h1234, 16);
        frame_end();
        n_vec++; if (obs_wr_q.size() !== exp_wr_q.size()) begin n_err++; $display("FAIL postrst_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); end
        while (exp_wr_q.size() != 0 && obs_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            n_vec++; if (obs_wr_q[0] !== e) begin n_err++; $display("FAIL postrst_write: got %0h want %0h", obs_wr_q[0], e); end
            void'(obs_wr_q.pop_front());
        end
        n_vec++; if (obs_rd_q.size() !== 0) begin n_err++; $display("FAIL postrst_no_rd: got %0d want 0", obs_rd_q.size()); end
    endtask

    task automatic test_strobe_spacing();
        n_vec++; if (collide_cnt !== 0) begin n_err++; $display("FAIL strobe_spacing: got %0d violations want 0", collide_cnt); end
    endtask

    initial begin
        miso_or = 1'b0;
        test_reset();
        test_write_fixed();
        test_write_wrap();
        test_read_incr();
        test_read_fixed();
        test_abort();
        test_reset_midread();
        test_strobe_spacing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
